// File: rtl/regfile_mp_pkg.sv
// Shared widths and FSM encodings for the multi-port register file.
// Imported by the interface, scoreboard and top.
package regfile_mp_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREGS = 32;
  localparam int DEF_AW    = 5;
  localparam int DEF_NRD   = 2;
  localparam int DEF_NWR   = 1;

  localparam logic [DEF_XLEN-1:0] ZERO_WORD = '0;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/regfile_mp_if.sv
// Register file access bundle: write, read, issue and status signals.
// The master drives requests; the slave (the register file) answers.
interface regfile_mp_if
  import regfile_mp_pkg::*;
#(
  parameter int XLEN = DEF_XLEN,
  parameter int AW   = DEF_AW,
  parameter int NRD  = DEF_NRD,
  parameter int NWR  = DEF_NWR
);
  logic                ready_o;
  logic [NWR-1:0]      we_i;
  logic [NWR*AW-1:0]   waddr_i;
  logic [NWR*XLEN-1:0] wdata_i;
  logic [NRD-1:0]      re_i;
  logic [NRD*AW-1:0]   raddr_i;
  logic [NRD*XLEN-1:0] rdata_o;
  logic [NRD-1:0]      busy_o;
  logic                iss_we_i;
  logic [AW-1:0]       iss_rd_i;

  modport master (
    input  ready_o, rdata_o, busy_o,
    output we_i, waddr_i, wdata_i,
    output re_i, raddr_i,
    output iss_we_i, iss_rd_i
  );

  modport slave (
    output ready_o, rdata_o, busy_o,
    input  we_i, waddr_i, wdata_i,
    input  re_i, raddr_i,
    input  iss_we_i, iss_rd_i
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register pending bits: issue sets, writeback clears, set wins.
// Busy per read port is suppressed when the same cycle writes the reg.
module regfile_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int NREGS   = DEF_NREGS,
  parameter int AW      = DEF_AW,
  parameter int NRD     = DEF_NRD,
  parameter int NWR     = DEF_NWR,
  parameter int ZERO_X0 = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              iss_we_i,
  input  logic [AW-1:0]     iss_rd_i,
  input  logic [NWR-1:0]    we_i,
  input  logic [NWR*AW-1:0] waddr_i,
  input  logic [NRD-1:0]    re_i,
  input  logic [NRD*AW-1:0] raddr_i,
  output logic [NRD-1:0]    busy_o
);
  logic [NREGS-1:0] pend_q;
  logic [NREGS-1:0] pend_d;

  always_comb begin
    pend_d = pend_q;
    for (int j = 0; j < NWR; j++) begin
      if (we_i[j]) pend_d[waddr_i[j*AW +: AW]] = 1'b0;
    end
    if (en_i && iss_we_i &&
        (ZERO_X0 == 0 || iss_rd_i != '0)) begin
      pend_d[iss_rd_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) pend_q <= '0;
    else       pend_q <= pend_d;
  end

  always_comb begin
    busy_o = '0;
    for (int k = 0; k < NRD; k++) begin
      busy_o[k] = en_i & re_i[k] & pend_q[raddr_i[k*AW +: AW]];
      for (int j = 0; j < NWR; j++) begin
        if (we_i[j] &&
            waddr_i[j*AW +: AW] == raddr_i[k*AW +: AW]) begin
          busy_o[k] = 1'b0;
        end
      end
    end
  end
endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with write bypass, post-reset zeroing
// sequencer and a pending-bit scoreboard for hazard detection.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int XLEN       = DEF_XLEN,
  parameter int NREGS      = DEF_NREGS,
  parameter int AW         = $clog2(NREGS),
  parameter int NRD        = DEF_NRD,
  parameter int NWR        = DEF_NWR,
  parameter int ZERO_X0    = 1,
  parameter int CLR_ON_RST = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  regfile_mp_if.slave rf
);
  state_e          state_q;
  logic [AW-1:0]   cnt_q;
  logic            ready_q;
  logic [XLEN-1:0] regs_q [NREGS];
  logic [NWR-1:0]  we_v;
  logic [NRD*XLEN-1:0] rdata_d;

  assign we_v       = rf.we_i & {NWR{ready_q}};
  assign rf.ready_o = ready_q;
  assign rf.rdata_o = rdata_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      unique case (state_q)
        INIT: begin
          cnt_q <= cnt_q + AW'(1);
          if (CLR_ON_RST == 0 || cnt_q == AW'(NREGS - 1)) begin
            state_q <= RUN;
            cnt_q   <= '0;
            ready_q <= 1'b1;
          end
        end
        RUN: ready_q <= 1'b1;
        default: state_q <= INIT;
      endcase
    end
  end

  // Zeroing and normal writes share one port into the array; later
  // write ports override earlier ones on an address collision.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (state_q == INIT) begin
        if (CLR_ON_RST != 0) regs_q[cnt_q] <= ZERO_WORD[XLEN-1:0];
      end else begin
        for (int j = 0; j < NWR; j++) begin
          if (we_v[j] &&
              !(ZERO_X0 != 0 && rf.waddr_i[j*AW +: AW] == '0)) begin
            regs_q[rf.waddr_i[j*AW +: AW]] <= rf.wdata_i[j*XLEN +: XLEN];
          end
        end
      end
    end
  end

  always_comb begin
    rdata_d = '0;
    for (int k = 0; k < NRD; k++) begin
      if (ready_q && rf.re_i[k] &&
          !(ZERO_X0 != 0 && rf.raddr_i[k*AW +: AW] == '0)) begin
        rdata_d[k*XLEN +: XLEN] = regs_q[rf.raddr_i[k*AW +: AW]];
        for (int j = 0; j < NWR; j++) begin
          if (we_v[j] &&
              rf.waddr_i[j*AW +: AW] == rf.raddr_i[k*AW +: AW]) begin
            rdata_d[k*XLEN +: XLEN] = rf.wdata_i[j*XLEN +: XLEN];
          end
        end
      end
    end
  end

  regfile_scoreboard #(
    .NREGS   (NREGS),
    .AW      (AW),
    .NRD     (NRD),
    .NWR     (NWR),
    .ZERO_X0 (ZERO_X0)
  ) u_sb (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en_i     (ready_q),
    .iss_we_i (rf.iss_we_i),
    .iss_rd_i (rf.iss_rd_i),
    .we_i     (we_v),
    .waddr_i  (rf.waddr_i),
    .re_i     (rf.re_i),
    .raddr_i  (rf.raddr_i),
    .busy_o   (rf.busy_o)
  );
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: two read ports, two write ports.
// Vector table for single-cycle behaviour plus reset/init sequences.
module tb_regfile_mp;
  import regfile_mp_pkg::*;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NRD  = 2;
  localparam int NWR  = 2;

  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  regfile_mp_if #(.XLEN(XLEN), .AW(AW), .NRD(NRD), .NWR(NWR)) bus ();

  regfile_mp #(
    .XLEN(XLEN), .NREGS(32), .AW(AW), .NRD(NRD), .NWR(NWR),
    .ZERO_X0(1), .CLR_ON_RST(1)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .rf    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [1:0]  re;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic        iss;
    logic [4:0]  ird;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  eb;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
    input logic [4:0] wa1, input logic [31:0] wd1,
    input logic [1:0] re, input logic [4:0] ra0, input logic [4:0] ra1,
    input logic iss, input logic [4:0] ird,
    input logic [31:0] e0, input logic [31:0] e1, input logic [1:0] eb);
    vec_t v;
    v.we = we; v.wa0 = wa0; v.wd0 = wd0; v.wa1 = wa1; v.wd1 = wd1;
    v.re = re; v.ra0 = ra0; v.ra1 = ra1; v.iss = iss; v.ird = ird;
    v.e0 = e0; v.e1 = e1; v.eb = eb;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.we_i     = '0;
    bus.waddr_i  = '0;
    bus.wdata_i  = '0;
    bus.re_i     = '0;
    bus.raddr_i  = '0;
    bus.iss_we_i = 1'b0;
    bus.iss_rd_i = '0;
  endtask

  task automatic drive(input vec_t v);
    bus.we_i     = v.we;
    bus.waddr_i  = {v.wa1, v.wa0};
    bus.wdata_i  = {v.wd1, v.wd0};
    bus.re_i     = v.re;
    bus.raddr_i  = {v.ra1, v.ra0};
    bus.iss_we_i = v.iss;
    bus.iss_rd_i = v.ird;
  endtask

  // Counts cycles with ready low after a reset edge; probes outputs once.
  task automatic wait_ready(input string nm, output int n);
    n = 0;
    while (bus.ready_o !== 1'b1 && n < 100) begin
      n++;
      if (n == 3) begin
        bus.re_i    = 2'b11;
        bus.raddr_i = {5'd5, 5'd4};
        #1;
        chk({nm, "_init_rdata0"}, bus.rdata_o[31:0], 32'h0);
        chk({nm, "_init_rdata1"}, bus.rdata_o[63:32], 32'h0);
        chk({nm, "_init_busy"}, {30'h0, bus.busy_o}, 32'h0);
      end
      step();
    end
  endtask

  initial begin
    int n;
    vec_t v;
    rst = 1'b1;
    idle();
    step();
    chk("rst_ready", {31'h0, bus.ready_o}, 32'h0);
    rst = 1'b0;
    wait_ready("first", n);
    chk("init_len", n, 32);
    idle();

    for (int i = 0; i < 16; i++) begin
      bus.re_i    = 2'b11;
      bus.raddr_i = {5'(2*i+1), 5'(2*i)};
      #1;
      chk($sformatf("zero_x%0d", 2*i), bus.rdata_o[31:0], 32'h0);
      chk($sformatf("zero_x%0d", 2*i+1), bus.rdata_o[63:32], 32'h0);
    end
    idle();
    step();

    vq.push_back(mk(2'b01, 5, 32'hDEADBEEF, 0, 0, 2'b11, 5, 6, 0, 0, 32'hDEADBEEF, 0, 2'b00));
    vq.push_back(mk(2'b00, 0, 0, 0, 0, 2'b11, 5, 0, 0, 0, 32'hDEADBEEF, 0, 2'b00));
    vq.push_back(mk(2'b11, 7, 32'h1111, 7, 32'h2222, 2'b11, 7, 7, 0, 0, 32'h2222, 32'h2222, 2'b00));
    vq.push_back(mk(2'b10, 0, 0, 0, 32'hFFFF, 2'b11, 7, 0, 0, 0, 32'h2222, 0, 2'b00));
    vq.push_back(mk(2'b00, 0, 0, 0, 0, 2'b01, 0, 5, 0, 0, 0, 0, 2'b00));
    vq.push_back(mk(2'b11, 8, 32'hAAAA, 8, 32'hBBBB, 2'b00, 8, 8, 0, 0, 0, 0, 2'b00));
    vq.push_back(mk(2'b00, 0, 0, 0, 0, 2'b11, 8, 0, 0, 0, 32'hBBBB, 0, 2'b00));
    vq.push_back(mk(2'b00, 0, 0, 0, 0, 2'b11, 3, 3, 1, 3, 0, 0, 2'b00));
    vq.push_back(mk(2'b00, 0, 0, 0, 0, 2'b11, 3, 3, 0, 0, 0, 0, 2'b11));
    vq.push_back(mk(2'b01, 3, 32'h42, 0, 0, 2'b11, 3, 3, 0, 0, 32'h42, 32'h42, 2'b00));
    vq.push_back(mk(2'b00, 0, 0, 0, 0, 2'b11, 3, 3, 0, 0, 32'h42, 32'h42, 2'b00));
    vq.push_back(mk(2'b10, 0, 0, 9, 32'h99, 2'b01, 9, 0, 1, 9, 32'h99, 0, 2'b00));
    vq.push_back(mk(2'b00, 0, 0, 0, 0, 2'b10, 9, 9, 0, 0, 0, 32'h99, 2'b10));
    vq.push_back(mk(2'b00, 0, 0, 0, 0, 2'b11, 9, 9, 0, 0, 32'h99, 32'h99, 2'b11));
    vq.push_back(mk(2'b00, 0, 0, 0, 0, 2'b01, 0, 0, 1, 0, 0, 0, 2'b00));
    vq.push_back(mk(2'b00, 0, 0, 0, 0, 2'b11, 0, 0, 0, 0, 0, 0, 2'b00));
    vq.push_back(mk(2'b00, 0, 0, 0, 0, 2'b01, 12, 0, 1, 12, 0, 0, 2'b00));
    vq.push_back(mk(2'b00, 0, 0, 0, 0, 2'b01, 12, 0, 1, 12, 0, 0, 2'b01));
    vq.push_back(mk(2'b00, 0, 0, 0, 0, 2'b01, 12, 0, 0, 0, 0, 0, 2'b01));
    vq.push_back(mk(2'b01, 12, 32'h77, 0, 0, 2'b11, 12, 12, 0, 0, 32'h77, 32'h77, 2'b00));
    vq.push_back(mk(2'b00, 0, 0, 0, 0, 2'b11, 12, 12, 0, 0, 32'h77, 32'h77, 2'b00));
    vq.push_back(mk(2'b01, 9, 32'h5, 0, 0, 2'b11, 9, 3, 0, 0, 32'h5, 32'h42, 2'b00));
    vq.push_back(mk(2'b00, 0, 0, 0, 0, 2'b11, 9, 7, 0, 0, 32'h5, 32'h2222, 2'b00));

    foreach (vq[i]) begin
      drive(vq[i]);
      #1;
      chk($sformatf("v%0d_rd0", i), bus.rdata_o[31:0], vq[i].e0);
      chk($sformatf("v%0d_rd1", i), bus.rdata_o[63:32], vq[i].e1);
      chk($sformatf("v%0d_busy", i), {30'h0, bus.busy_o}, {30'h0, vq[i].eb});
      step();
    end
    idle();

    v = mk(2'b01, 4, 32'h55, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 2'b00);
    drive(v);
    step();
    idle();
    bus.iss_we_i = 1'b1;
    bus.iss_rd_i = 5'd4;
    step();
    idle();
    bus.re_i    = 2'b01;
    bus.raddr_i = {5'd0, 5'd4};
    #1;
    chk("pre_rst_x4", bus.rdata_o[31:0], 32'h55);
    chk("pre_rst_busy", {30'h0, bus.busy_o}, 32'h1);

    step();
    rst = 1'b1;
    bus.we_i     = 2'b01;
    bus.waddr_i  = {5'd0, 5'd4};
    bus.wdata_i  = {32'h0, 32'hAA};
    bus.iss_we_i = 1'b1;
    bus.iss_rd_i = 5'd4;
    step();
    chk("run_rst_ready", {31'h0, bus.ready_o}, 32'h0);
    rst = 1'b0;
    wait_ready("rerst", n);
    chk("reinit_len", n, 32);
    idle();
    bus.re_i    = 2'b11;
    bus.raddr_i = {5'd5, 5'd4};
    #1;
    chk("post_rst_x4", bus.rdata_o[31:0], 32'h0);
    chk("post_rst_x5", bus.rdata_o[63:32], 32'h0);
    chk("post_rst_busy", {30'h0, bus.busy_o}, 32'h0);
    step();
    chk("post_rst_busy2", {30'h0, bus.busy_o}, 32'h0);
    chk("post_rst_ready", {31'h0, bus.ready_o}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
